// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: fixed-latency SRAM responder for a pipeline data bus.
// Types: dbus_pkg::dbus_req_t (valid, addr, size, strobe, data), dbus_pkg::dbus_resp_t (addr_ok, data_ok, data).
// Ports: clk (rising edge), reset (sync, active high), dreq (request in), dresp (response out),
//        busy (high while an accepted request has not completed).
// Option: define DBUS_RESP_STALL_EN to gate acceptance with a pseudo-random LFSR stall.
package dbus_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;
    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;
endpackage

module dbus_sram_responder
    import dbus_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       busy
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]    r_state;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_idx;
    logic [3:0]    r_strb;
    logic [31:0]   r_wdata;
    logic          r_wr;
    logic [31:0]   r_mem [MEM_WORDS];
    logic          w_gate;
    logic          w_accept;
    logic          w_done;
    logic          w_unused;

    // size and the address bits outside the word index never affect behaviour
    assign w_unused = ^{dreq.size, dreq.addr[31:AW+2], dreq.addr[1:0]};

`ifdef DBUS_RESP_STALL_EN
    logic [15:0] r_lfsr;
    logic [3:0]  r_stall;
    // r_stall counts consecutive blocked cycles; after 15 the next one is forced open
    assign w_gate = r_lfsr[0] || (r_stall == 4'd15);
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr  <= 16'hACE1;
            r_stall <= '0;
        end else begin
            r_lfsr  <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            r_stall <= (r_state == S_IDLE && dreq.valid && !w_gate) ? r_stall + 4'd1 : 4'd0;
        end
    end
`else
    assign w_gate = 1'b1;
`endif

    assign w_accept = !reset && r_state == S_IDLE && dreq.valid && w_gate;
    assign w_done   = r_state == S_BUSY && r_cnt == 4'd0;

    always_comb begin
        dresp.addr_ok = w_accept;
        dresp.data_ok = w_done;
        dresp.data    = (w_done && !r_wr) ? r_mem[r_idx] : 32'd0;
        busy          = r_state == S_BUSY;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_state <= S_BUSY;
            r_cnt   <= 4'(LATENCY - 1);
            r_idx   <= dreq.addr[AW+1:2];
            r_strb  <= dreq.strobe;
            r_wdata <= dreq.data;
            r_wr    <= |dreq.strobe;
        end else if (r_state == S_BUSY) begin
            r_state <= w_done ? S_IDLE : S_BUSY;
            r_cnt   <= w_done ? 4'd0 : r_cnt - 4'd1;
        end
    end

    // Writes commit at the edge closing the data_ok cycle; reset on that edge drops them
    always_ff @(posedge clk) begin
        if (w_done && r_wr && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (r_strb[b]) r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dbus_sram_responder.sv
// tb_dbus_sram_responder: randomized and directed checks of dbus_sram_responder against a word-array model.
module tb_dbus_sram_responder;
    import dbus_pkg::*;
    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       reset;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    logic       busy;
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    logic [31:0] model [16];

    dbus_sram_responder #(.MEM_WORDS(1024), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .dreq(dreq), .dresp(dresp), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Word index idx placed in addr[11:2], with random junk in the ignored bits
    function automatic logic [31:0] noisy(input int idx);
        logic [31:0] a = $urandom;
        a[11:2] = 10'(idx);
        return a;
    endfunction

    task automatic xact(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                        input int idx, output int acc_cyc);
        int w = 0;
        logic [31:0] exp;
        @(negedge clk);
        dreq.valid = 1'b1; dreq.addr = addr; dreq.size = 3'($urandom); dreq.strobe = strb; dreq.data = wd;
        #1;
        while (!dresp.addr_ok && w < 20) begin
            @(negedge clk); #1; w++;
        end
        acc_cyc = cyc;
`ifdef DBUS_RESP_STALL_EN
        chk("accept_wait", 32'(w <= 16), 32'd1);
`else
        chk("accept_wait", 32'(w), 32'd0);
`endif
        chk("data_ok_at_accept", 32'(dresp.data_ok), 32'd0);
        chk("busy_at_accept", 32'(busy), 32'd0);
        exp = (strb == 4'd0) ? model[idx] : 32'd0;
        if (strb != 4'd0) model[idx] = merge(model[idx], wd, strb);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            dreq.addr = $urandom; dreq.strobe = 4'($urandom); dreq.data = $urandom;
            #1;
            chk("data_ok", 32'(dresp.data_ok), 32'(k == LAT));
            chk("addr_ok_while_busy", 32'(dresp.addr_ok), 32'd0);
            chk("busy", 32'(busy), 32'd1);
            chk("data", dresp.data, (k == LAT) ? exp : 32'd0);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        dreq.valid = 1'b0;
    endtask

    initial begin
        int a, prev, idx, w;
        logic [3:0] s;
        reset = 1'b1;
        dreq = '0;
        dreq.valid = 1'b1;
        repeat (3) @(negedge clk);
        #1 chk("addr_ok_in_reset", 32'(dresp.addr_ok), 32'd0);
        @(negedge clk);
        reset = 1'b0; dreq.valid = 1'b0;
        #1;
        chk("rst_addr_ok", 32'(dresp.addr_ok), 32'd0);
        chk("rst_data_ok", 32'(dresp.data_ok), 32'd0);
        chk("rst_data", dresp.data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 16; i++) begin
            xact(32'(i * 4), 4'hf, $urandom, i, a);
            idle();
        end
        xact(32'h10, 4'hf, 32'h11223344, 4, a); idle();
        xact(32'h10, 4'h0, 32'h0, 4, a); idle();
        xact(32'h12, 4'h0, 32'h0, 4, a); idle();
        xact(32'h10, 4'b0101, 32'hAABBCCDD, 4, a); idle();
        xact(32'h10, 4'h0, 32'h0, 4, a); idle();
        xact(noisy(4), 4'h0, 32'h0, 4, prev);
        for (int i = 0; i < 6; i++) begin
            idx = int'($urandom_range(0, 15));
            xact(noisy(idx), 4'h0, 32'h0, idx, a);
`ifndef DBUS_RESP_STALL_EN
            chk("b2b_spacing", 32'(a - prev), 32'd3);
`endif
            prev = a;
        end
        idle();
        @(negedge clk);
        w = 0;
        dreq.valid = 1'b1; dreq.addr = 32'h20; dreq.strobe = 4'hf; dreq.data = ~model[8];
        #1;
        while (!dresp.addr_ok && w < 20) begin
            @(negedge clk); #1; w++;
        end
        chk("rstw_accepted", 32'(dresp.addr_ok), 32'd1);
        @(negedge clk);
        reset = 1'b1; dreq.valid = 1'b0;
        #1 chk("rstw_addr_ok_in_reset", 32'(dresp.addr_ok), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rstw_busy", 32'(busy), 32'd0);
        chk("rstw_data_ok", 32'(dresp.data_ok), 32'd0);
        repeat (3) @(negedge clk);
        xact(32'h20, 4'h0, 32'h0, 8, a); idle();
        for (int i = 0; i < 150; i++) begin
            idx = int'($urandom_range(0, 15));
            s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            xact(noisy(idx), s, $urandom, idx, a);
            if ($urandom_range(0, 2) == 0) idle();
        end
        idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
